// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order commit queue with CDB write-back and mispredict flush
// Optional macro ROB_OPERAND_FWD_EN enables the combinational operand forwarding ports.
module reorder_buffer #(
  parameter int          RoB_WIDTH = 3,
  parameter logic [5:0]  NON_DEP   = 6'b100000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic [31:0]          issue_pc,
  input  logic                 issue_pred_taken,
  output logic [RoB_WIDTH-1:0] issue_index,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [RoB_WIDTH-1:0] cdb_index,
  input  logic [31:0]          cdb_value,
  input  logic                 cdb_taken,
  input  logic [31:0]          cdb_target,
  output logic                 RoB_update_en,
  output logic [5:0]           RoB_update_reg,
  output logic [RoB_WIDTH-1:0] RoB_update_index,
  output logic [31:0]          RoB_update_data,
  output logic                 store_commit_en,
  output logic [RoB_WIDTH-1:0] store_commit_index,
  output logic                 flush_signal,
  output logic [31:0]          flush_pc,
  output logic                 halt_out,
  input  logic [RoB_WIDTH-1:0] fwd_idx1,
  input  logic [RoB_WIDTH-1:0] fwd_idx2,
  output logic                 fwd_ready1,
  output logic                 fwd_ready2,
  output logic [31:0]          fwd_value1,
  output logic [31:0]          fwd_value2
);

  localparam int DEPTH = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0] FULL_CNT = (RoB_WIDTH+1)'(DEPTH);
  localparam logic [1:0] T_BRANCH = 2'd1;
  localparam logic [1:0] T_STORE  = 2'd2;
  localparam logic [1:0] T_HALT   = 2'd3;

  logic [DEPTH-1:0]     e_busy;
  logic [DEPTH-1:0]     e_ready;
  logic [1:0]           e_type   [DEPTH];
  logic [4:0]           e_rd     [DEPTH];
  logic [31:0]          e_pc     [DEPTH];
  logic                 e_pred   [DEPTH];
  logic [31:0]          e_value  [DEPTH];
  logic                 e_taken  [DEPTH];
  logic [31:0]          e_target [DEPTH];

  logic [RoB_WIDTH-1:0] head;
  logic [RoB_WIDTH-1:0] tail;
  logic [RoB_WIDTH:0]   count;
  logic [RoB_WIDTH:0]   count_next;
  // A flush that lands while rdy_in is low is remembered so it is not lost.
  logic                 flush_hold;
  logic                 issue_ok;
  logic                 do_commit;
  logic                 mispredict;

  assign issue_index = tail;
  assign issue_ok  = rdy_in && issue_valid && !full && !flush_signal && !flush_hold && !halt_out;
  assign do_commit = rdy_in && !flush_signal && !flush_hold && !halt_out
                     && e_busy[head] && e_ready[head];
  assign mispredict = (e_type[head] == T_BRANCH) && (e_taken[head] != e_pred[head]);

  always_comb begin
    count_next = count;
    if (issue_ok && !do_commit)
      count_next = count + 1'b1;
    else if (!issue_ok && do_commit)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      e_busy             <= '0;
      e_ready            <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_type[i]   <= '0;
        e_rd[i]     <= '0;
        e_pc[i]     <= '0;
        e_pred[i]   <= 1'b0;
        e_value[i]  <= '0;
        e_taken[i]  <= 1'b0;
        e_target[i] <= '0;
      end
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      full               <= 1'b0;
      flush_hold         <= 1'b0;
      RoB_update_en      <= 1'b0;
      RoB_update_reg     <= NON_DEP;
      RoB_update_index   <= '0;
      RoB_update_data    <= '0;
      store_commit_en    <= 1'b0;
      store_commit_index <= '0;
      flush_signal       <= 1'b0;
      flush_pc           <= '0;
      halt_out           <= 1'b0;
    end else if (!rdy_in) begin
      RoB_update_en   <= 1'b0;
      store_commit_en <= 1'b0;
      flush_signal    <= 1'b0;
      if (flush_signal)
        flush_hold <= 1'b1;
    end else if (flush_signal || flush_hold) begin
      e_busy          <= '0;
      e_ready         <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      full            <= 1'b0;
      flush_hold      <= 1'b0;
      RoB_update_en   <= 1'b0;
      store_commit_en <= 1'b0;
      flush_signal    <= 1'b0;
    end else begin
      RoB_update_en   <= 1'b0;
      store_commit_en <= 1'b0;

      if (cdb_valid && e_busy[cdb_index]) begin
        e_value[cdb_index]  <= cdb_value;
        e_taken[cdb_index]  <= cdb_taken;
        e_target[cdb_index] <= cdb_target;
        e_ready[cdb_index]  <= 1'b1;
      end

      // Issue comes after the CDB write so a fresh entry never inherits a stale ready.
      if (issue_ok) begin
        e_busy[tail]   <= 1'b1;
        e_ready[tail]  <= (issue_type == T_HALT);
        e_type[tail]   <= issue_type;
        e_rd[tail]     <= issue_rd;
        e_pc[tail]     <= issue_pc;
        e_pred[tail]   <= issue_pred_taken;
        tail           <= tail + 1'b1;
      end

      if (do_commit) begin
        e_busy[head] <= 1'b0;
        head         <= head + 1'b1;
        case (e_type[head])
          T_STORE: begin
            store_commit_en    <= 1'b1;
            store_commit_index <= head;
          end
          T_HALT: begin
            halt_out <= 1'b1;
          end
          default: begin
            RoB_update_en    <= 1'b1;
            RoB_update_reg   <= (e_rd[head] == 5'd0) ? NON_DEP : {1'b0, e_rd[head]};
            RoB_update_index <= head;
            RoB_update_data  <= e_value[head];
            if (mispredict) begin
              flush_signal <= 1'b1;
              flush_pc     <= e_taken[head] ? e_target[head] : e_pc[head] + 32'd4;
            end
          end
        endcase
      end

      count <= count_next;
      full  <= (count_next == FULL_CNT);
    end
  end

`ifdef ROB_OPERAND_FWD_EN
  always_comb begin
    fwd_ready1 = e_ready[fwd_idx1];
    fwd_value1 = e_value[fwd_idx1];
    if (cdb_valid && e_busy[fwd_idx1] && cdb_index == fwd_idx1) begin
      fwd_ready1 = 1'b1;
      fwd_value1 = cdb_value;
    end
    fwd_ready2 = e_ready[fwd_idx2];
    fwd_value2 = e_value[fwd_idx2];
    if (cdb_valid && e_busy[fwd_idx2] && cdb_index == fwd_idx2) begin
      fwd_ready2 = 1'b1;
      fwd_value2 = cdb_value;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_idx1, fwd_idx2};
  assign fwd_ready1 = 1'b0;
  assign fwd_ready2 = 1'b0;
  assign fwd_value1 = '0;
  assign fwd_value2 = '0;
`endif

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit queue between the Dispatcher and the register file (RF).
- Allocates one entry per issued instruction and records CDB write-back results.
- Retires at most one entry per cycle from the head, driving the RF update bus.
- Detects branch mispredicts at commit, then raises a one-cycle flush with a redirect PC.

Parameters:
RoB_WIDTH, 3, log2 of entry count (DEPTH = 8)
NON_DEP, 32 (6'b100000), "no register" encoding on 6-bit register fields

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global run enable; low = pause
issue_valid  in  1  Dispatcher presents an instruction
issue_type  in  2  0=ALU/load, 1=branch, 2=store, 3=halt
issue_rd  in  5  destination register (0 = none)
issue_pc  in  32  instruction PC
issue_pred_taken  in  1  predictor decision (branches)
issue_index  out  RoB_WIDTH  tail index allocated if issue accepted (combinational)
full  out  1  count == DEPTH (registered)
cdb_valid  in  1  write-back strobe
cdb_index  in  RoB_WIDTH  entry being completed
cdb_value  in  32  result / link value
cdb_taken  in  1  resolved branch direction
cdb_target  in  32  resolved taken target
RoB_update_en  out  1  commit pulse to RF
RoB_update_reg  out  6  {0,rd}, or NON_DEP if rd==0
RoB_update_index  out  RoB_WIDTH  committed entry index
RoB_update_data  out  32  committed value
store_commit_en  out  1  pulse: head store may write memory
store_commit_index  out  RoB_WIDTH  index of committing store
flush_signal  out  1  mispredict flush pulse
flush_pc  out  32  redirect PC, valid with flush_signal
halt_out  out  1  sticky, set when halt entry commits

Behaviour:
- Entry fields: busy, ready, type, rd, pc, pred_taken, value, taken, target. Pointers: head, tail (RoB_WIDTH bits, natural wrap). Counter: count (RoB_WIDTH+1 bits).
- Reset (rst_in low, async): all entries not busy; head=tail=count=0; every registered output 0; RoB_update_reg=NON_DEP.
- rdy_in low: all state frozen; RoB_update_en, store_commit_en, flush_signal driven 0 the following cycle; halt_out held.
- Issue: accepted when issue_valid && !full && !flush_signal. The entry at tail is written busy=1, ready=(type==3), then tail+1.
- Write-back: on cdb_valid to a busy entry, store value/taken/target and set ready=1. A write to a non-busy entry is ignored. A store's ready comes via the CDB like any other entry.
- Commit: at a clock edge, if !flush_signal && busy[head] && ready[head]:
  - free head; head+1; outputs registered, valid the next cycle.
  - Latency: CDB write-back at edge N makes commit outputs appear after edge N+1.
  - type 0 or 1: RoB_update_en=1, reg/index/data from the entry.
  - type 2: store_commit_en=1, store_commit_index=head; RoB_update_en=0.
  - type 3: halt_out<=1; no further commits or issues afterwards.
  - type 1 with taken != pred_taken: additionally flush_signal=1, flush_pc = taken ? target : pc+4.
- Outputs are single-cycle pulses, cleared at the next edge unless a new commit occurs.
- Flush: the edge ending the flush_signal cycle clears all busy bits and sets head=tail=count=0. Issue and CDB are ignored in that cycle, and no commit occurs.
- count: +1 on issue only, -1 on commit only, unchanged when both occur.
- full is registered, so an entry freed by commit becomes allocatable one cycle later.
- Wrap: tail index 7 then 0; full at count 8, empty at count 0; no commit when empty.

Optional Feature:
- ROB_OPERAND_FWD_EN:
  - When defined, adds inputs fwd_idx1/fwd_idx2 (RoB_WIDTH) and outputs fwd_ready1/2 (1) and fwd_value1/2 (32).
  - These combinationally return ready and value of the named entry, with the same-cycle CDB write to that index bypassed in.
  - This lets the Dispatcher resolve a dependency whose producer has finished but not yet committed.
  - When undefined, the ports are still present; the outputs are tied to 0 and the inputs are ignored.

Test Plan:
- Issue type0 rd=5 pc=0x100 → issue_index=0; cdb idx0 value 0xDEADBEEF; two edges later RoB_update_en=1, reg=6'd5, index=0, data=0xDEADBEEF for exactly one cycle.
- Issue 8 entries without write-back → full=1; 9th issue ignored (tail stays 0); complete entry 0 → commit, full=0 one cycle after commit.
- Branch pc=0x200, pred_taken=0, cdb_taken=1, target=0x300, younger entries present → flush_signal=1, flush_pc=0x300; next cycle count=0, issue_index=0, no younger commits.
- Branch pred_taken=1, cdb_taken=0, pc=0x40 → flush_pc=0x44; correctly predicted branch → no flush, RoB_update_en=1 with rd value.
- Out-of-order write-back of entries 2,1,0 → commits in order 0,1,2 on consecutive cycles; rd=0 entry commits with RoB_update_reg=6'b100000.
- rst_in low mid-run with 5 busy entries → immediately all outputs 0, count=0; rdy_in low for 3 cycles with head ready → no commit until rdy_in returns.
